// File: rtl/mimo_frame_packer.sv
// Packs a serial stream of complex Q6.10 samples into NUM_ANT-lane words for the MIMO detector,
// tagging channel/data words and tracking frame sync (channel words then data words per frame).
module mimo_frame_packer #(
  parameter int I_WIDTH        = 16,
  parameter int NUM_ANT        = 4,
  parameter int NUM_CH_WORDS   = 4,
  parameter int NUM_DATA_WORDS = 11
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           s_sof,
  input  logic [2*I_WIDTH-1:0]           s_data,
  output logic                           m_valid,
  output logic                           m_flag,
  output logic [NUM_ANT*2*I_WIDTH-1:0]   m_data,
  input  logic                           m_ready,
  output logic                           frame_done,
  output logic                           frame_err
);

  localparam int SW        = 2 * I_WIDTH;
  localparam int WW        = NUM_ANT * SW;
  localparam int NUM_WORDS = NUM_CH_WORDS + NUM_DATA_WORDS;
  localparam int LANE_W    = (NUM_ANT > 1) ? $clog2(NUM_ANT) : 1;
  localparam int WORD_W    = $clog2(NUM_WORDS + 1);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_CHAN = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
  logic [WW-1:0]     pack_data_q, pack_data_d;
  logic              pack_flag_q, pack_flag_d;
  logic              pack_full_q, pack_full_d;
  logic [WW-1:0]     out_data_q, out_data_d;
  logic              out_flag_q, out_flag_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              xfer;
  logic              wr_en;
  logic [LANE_W-1:0] wr_lane;
  logic [WORD_W-1:0] word_inc;

  assign accept   = s_valid && !pack_full_q;
  assign xfer     = pack_full_q && (!out_valid_q || m_ready);
  assign word_inc = word_cnt_q + WORD_W'(1);

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    word_cnt_d  = word_cnt_q;
    pack_data_d = pack_data_q;
    pack_flag_d = pack_flag_q;
    pack_full_d = pack_full_q;
    out_data_d  = out_data_q;
    out_flag_d  = out_flag_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    wr_lane     = '0;

    // Output slot: a pack transfer on a handshake edge replaces the old word with no bubble.
    if (xfer) begin
      out_data_d  = pack_data_q;
      out_flag_d  = pack_flag_q;
      out_valid_d = 1'b1;
      pack_full_d = 1'b0;
    end else if (m_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (state_q == ST_HUNT && !s_sof) begin
        err_d = 1'b1;
      end else if (s_sof && (state_q == ST_HUNT || lane_cnt_q != '0 || word_cnt_q != '0)) begin
        // Start (or restart) a frame; any partial lanes are simply overwritten later.
        err_d      = (state_q != ST_HUNT);
        wr_en      = 1'b1;
        wr_lane    = '0;
        lane_cnt_d = LANE_W'(1);
        word_cnt_d = '0;
        state_d    = ST_CHAN;
      end else begin
        wr_en   = 1'b1;
        wr_lane = lane_cnt_q;
        if (lane_cnt_q == LANE_W'(NUM_ANT - 1)) begin
          pack_full_d = 1'b1;
          pack_flag_d = (state_q == ST_CHAN);
          lane_cnt_d  = '0;
          word_cnt_d  = word_inc;
          if (state_q == ST_CHAN && word_inc == WORD_W'(NUM_CH_WORDS)) begin
            state_d = ST_DATA;
          end else if (state_q == ST_DATA && word_inc == WORD_W'(NUM_WORDS)) begin
            state_d    = ST_HUNT;
            word_cnt_d = '0;
            done_d     = 1'b1;
          end
        end else begin
          lane_cnt_d = lane_cnt_q + LANE_W'(1);
        end
      end
    end

    for (int unsigned k = 0; k < NUM_ANT; k++) begin
      if (wr_en && wr_lane == LANE_W'(k)) begin
        pack_data_d[(NUM_ANT - k) * SW - 1 -: SW] = s_data;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_HUNT;
      lane_cnt_q  <= '0;
      word_cnt_q  <= '0;
      pack_data_q <= '0;
      pack_flag_q <= 1'b0;
      pack_full_q <= 1'b0;
      out_data_q  <= '0;
      out_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      word_cnt_q  <= word_cnt_d;
      pack_data_q <= pack_data_d;
      pack_flag_q <= pack_flag_d;
      pack_full_q <= pack_full_d;
      out_data_q  <= out_data_d;
      out_flag_q  <= out_flag_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_ready    = !pack_full_q;
  assign m_valid    = out_valid_q;
  assign m_flag     = out_flag_q;
  assign m_data     = out_data_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_mimo_frame_packer.sv
// Self-checking bench for mimo_frame_packer: sample streams are checked against a
// frame-position reference model plus direct constant checks on reset, flags and holds.
module tb_mimo_frame_packer;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         s_sof = 1'b0;
  logic [31:0]  s_data = '0;
  logic         m_valid;
  logic         m_flag;
  logic [127:0] m_data;
  logic         m_ready = 1'b0;
  logic         frame_done;
  logic         frame_err;

  mimo_frame_packer #(
    .I_WIDTH(16), .NUM_ANT(4), .NUM_CH_WORDS(4), .NUM_DATA_WORDS(11)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
    .m_valid(m_valid), .m_flag(m_flag), .m_data(m_data), .m_ready(m_ready),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [128:0] got_q[$];
  logic [128:0] exp_q[$];
  bit           stim_sof[$];
  logic [31:0]  stim_dat[$];
  int           exp_err, exp_done;

  int           err_pulses = 0, done_pulses = 0, hold_viol = 0, valid_cycles = 0;
  logic         prev_stall = 1'b0;
  logic [128:0] prev_word = '0;

  // Passive monitor: words are captured on handshake cycles, pulses counted per high cycle.
  always @(negedge Clk) begin
    if (Reset_n && prev_stall && (!m_valid || {m_flag, m_data} !== prev_word)) hold_viol++;
    prev_stall = m_valid && !m_ready && Reset_n;
    prev_word  = {m_flag, m_data};
    if (m_valid) valid_cycles++;
    if (m_valid && m_ready) got_q.push_back({m_flag, m_data});
    if (frame_err) err_pulses++;
    if (frame_done) done_pulses++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] samp(input int i);
    return {16'(i), 16'(-i)};
  endfunction

  // Reference: position within frame decides lane, word index, flag and frame end.
  task automatic model_run();
    int pos;
    logic [127:0] w;
    pos = -1; w = '0;
    exp_q.delete(); exp_err = 0; exp_done = 0;
    for (int i = 0; i < stim_sof.size(); i++) begin
      if (stim_sof[i]) begin
        if (pos > 0) exp_err++;
        pos = 0;
      end else if (pos < 0) begin
        exp_err++;
        continue;
      end
      w[127 - 32 * (pos % 4) -: 32] = stim_dat[i];
      if (pos % 4 == 3) exp_q.push_back({(pos / 4 < 4), w});
      if (pos == 59) begin exp_done++; pos = -1; end
      else pos++;
    end
  endtask

  task automatic clear_stim();
    stim_sof.delete(); stim_dat.delete(); got_q.delete();
  endtask

  task automatic add_seq(input int first, input int last, input int sof_at);
    for (int i = first; i <= last; i++) begin
      stim_sof.push_back(i == sof_at);
      stim_dat.push_back(samp(i));
    end
  endtask

  task automatic add_rand(input int n, input bit sof_first);
    for (int i = 0; i < n; i++) begin
      stim_sof.push_back(sof_first && i == 0);
      stim_dat.push_back($urandom);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the last sample is accepted.
  task automatic drive_stream(input int idle_pct);
    bit acc;
    int t;
    for (int i = 0; i < stim_sof.size(); i++) begin
      while ($urandom_range(99) < idle_pct) begin
        s_valid = 1'b0;
        @(posedge Clk); #1;
      end
      s_valid = 1'b1; s_sof = stim_sof[i]; s_data = stim_dat[i];
      t = 0;
      do begin
        acc = s_ready;
        @(posedge Clk); #1;
        t++;
      end while (!acc && t < 2000);
      if (!acc) begin
        errors++; checks++;
        $display("FAIL accept_timeout sample %0d: s_ready stuck at 0, required 1", i);
        break;
      end
    end
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic drain(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 3000) begin
      @(posedge Clk); #1; t++;
    end
    repeat (8) begin @(posedge Clk); #1; end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({m_valid, m_flag, frame_done, frame_err} !== 4'b0000 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b f=%b d=%h done=%b err=%b, required all 0",
               m_valid, m_flag, m_data, frame_done, frame_err);
    end
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready);
    end
  endtask

  task automatic test_nominal();
    int e0, d0;
    clear_stim(); add_seq(0, 59, 0); model_run();
    e0 = err_pulses; d0 = done_pulses;
    m_ready = 1'b1;
    drive_stream(0);
    drain(15);
    checks++;
    if (got_q.size() !== 15) begin
      errors++; $display("FAIL nominal_count: got %0d words required 15", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i][128] !== (i < 4)) begin
        errors++; $display("FAIL nominal_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() > 0 && got_q[0] !== {1'b1, 16'd0, 16'd0, 16'd1, 16'hffff, 16'd2, 16'hfffe, 16'd3, 16'hfffd}) begin
      errors++; $display("FAIL nominal_word0_const: got %h", got_q[0]);
    end
    checks++;
    if (done_pulses - d0 !== 1 || err_pulses - e0 !== 0) begin
      errors++; $display("FAIL nominal_pulses: done %0d err %0d, required 1 and 0",
                         done_pulses - d0, err_pulses - e0);
    end
  endtask

  task automatic test_backpressure();
    int h0, t;
    logic [128:0] held;
    clear_stim(); add_seq(0, 59, 0); model_run();
    h0 = hold_viol;
    m_ready = 1'b1;
    fork
      drive_stream(0);
      begin
        t = 0;
        while (!(m_valid && got_q.size() == 2) && t < 1000) begin
          @(posedge Clk); #1; t++;
        end
        m_ready = 1'b0;
        held = {m_flag, m_data};
        repeat (10) begin @(posedge Clk); #1; end
        checks++;
        if ({m_flag, m_data} !== held || held !== exp_q[2] || !m_valid) begin
          errors++; $display("FAIL bp_hold: got %h v=%b, required %h held", {m_flag, m_data}, m_valid, exp_q[2]);
        end
        checks++;
        if (s_ready !== 1'b0) begin
          errors++; $display("FAIL bp_s_ready: got %b required 0", s_ready);
        end
        m_ready = 1'b1;
      end
    join
    drain(15);
    checks++;
    if (got_q.size() !== 15 || hold_viol !== h0) begin
      errors++; $display("FAIL bp_count: words %0d hold_viol %0d, required 15 and 0",
                         got_q.size(), hold_viol - h0);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_missing_sof();
    int e0, v0, d0;
    clear_stim();
    add_seq(100, 102, -1);
    e0 = err_pulses; v0 = valid_cycles; d0 = done_pulses;
    m_ready = 1'b1;
    drive_stream(0);
    repeat (4) begin @(posedge Clk); #1; end
    checks++;
    if (err_pulses - e0 !== 3 || valid_cycles !== v0) begin
      errors++; $display("FAIL missing_sof: err pulses %0d valid cycles %0d, required 3 and 0",
                         err_pulses - e0, valid_cycles - v0);
    end
    clear_stim(); add_seq(0, 59, 0); model_run();
    drive_stream(20);
    drain(15);
    checks++;
    if (got_q.size() !== 15 || done_pulses - d0 !== 1) begin
      errors++; $display("FAIL missing_sof_frame: words %0d done %0d, required 15 and 1",
                         got_q.size(), done_pulses - d0);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL missing_sof_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_early_sof();
    int e0;
    logic [127:0] w5;
    clear_stim(); add_seq(0, 21, 0); add_seq(22, 81, 22); model_run();
    for (int k = 0; k < 4; k++) w5[127 - 32 * k -: 32] = samp(22 + k);
    e0 = err_pulses;
    m_ready = 1'b1;
    drive_stream(0);
    drain(20);
    checks++;
    if (err_pulses - e0 !== 1 || got_q.size() !== 20) begin
      errors++; $display("FAIL early_sof: err %0d words %0d, required 1 and 20", err_pulses - e0, got_q.size());
    end
    checks++;
    if (got_q.size() > 5 && got_q[5] !== {1'b1, w5}) begin
      errors++; $display("FAIL early_sof_restart_word: got %h required %h", got_q[5], {1'b1, w5});
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL early_sof_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_stim(); add_seq(0, 23, 0);
    m_ready = 1'b1;
    drive_stream(0);
    drain(6);
    m_ready = 1'b0;
    clear_stim(); add_seq(24, 27, -2);
    drive_stream(0);
    repeat (3) begin @(posedge Clk); #1; end
    checks++;
    if (m_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_setup: m_valid %b required 1 (word 6 held)", m_valid);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0) begin
      errors++; $display("FAIL rst_mid_async: m_valid %b data %h, required 0", m_valid, m_data);
    end
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release: s_ready %b m_valid %b, required 1 and 0", s_ready, m_valid);
    end
    m_ready = 1'b1;
    clear_stim(); add_seq(200, 259, 200); model_run();
    drive_stream(0);
    drain(15);
    checks++;
    if (got_q.size() !== 15) begin
      errors++; $display("FAIL rst_mid_count: got %0d words required 15", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rst_mid_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e0, d0;
    clear_stim(); add_seq(0, 59, 0); add_seq(60, 119, 60); model_run();
    e0 = err_pulses; d0 = done_pulses;
    m_ready = 1'b1;
    drive_stream(0);
    drain(30);
    checks++;
    if (got_q.size() !== 30 || done_pulses - d0 !== 2 || err_pulses - e0 !== 0) begin
      errors++; $display("FAIL b2b_summary: words %0d done %0d err %0d, required 30 2 0",
                         got_q.size(), done_pulses - d0, err_pulses - e0);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i][128] !== ((i % 15) < 4)) begin
        errors++; $display("FAIL b2b_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int e0, d0, h0;
    bit stop;
    clear_stim();
    add_rand(2, 1'b0);
    add_rand(60, 1'b1);
    add_rand(30, 1'b1);
    add_rand(60, 1'b1);
    add_rand(1, 1'b0);
    add_rand(60, 1'b1);
    model_run();
    e0 = err_pulses; d0 = done_pulses; h0 = hold_viol;
    stop = 1'b0;
    fork
      begin drive_stream(30); stop = 1'b1; end
      begin
        while (!stop) begin
          m_ready = 1'($urandom_range(1));
          @(posedge Clk); #1;
        end
        m_ready = 1'b1;
      end
    join
    drain(exp_q.size());
    checks++;
    if (got_q.size() !== exp_q.size() || err_pulses - e0 !== exp_err ||
        done_pulses - d0 !== exp_done || hold_viol !== h0) begin
      errors++; $display("FAIL random_summary: words %0d/%0d err %0d/%0d done %0d/%0d hold_viol %0d",
                         got_q.size(), exp_q.size(), err_pulses - e0, exp_err,
                         done_pulses - d0, exp_done, hold_viol - h0);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL random_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_missing_sof();
    test_early_sof();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mimo_frame_packer.md
Name: mimo_frame_packer

Overview:
- Upstream feeder for MIMO_detector.
- Accepts a serial stream of complex Q6.10 samples, one per beat, and packs four samples into one 128-bit InData word.
- Tags each word as channel or data (flagChannelorData) and delivers it under the detector's o_in_ready backpressure.
- Owns frame sync: 4 channel words (H rows) followed by 11 data vectors per frame.

Parameters:
- I_WIDTH, 16, width of one real or imaginary part (INT_W 6 + FRAC_W 10).
- NUM_ANT, 4, complex samples per packed word.
- NUM_CH_WORDS, 4, channel words per frame (flag=1).
- NUM_DATA_WORDS, 11, data words per frame (flag=0).

Ports:
- Clk  in  1  clock; all state on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid&&s_ready.
- s_sof  in  1  marks first sample of a frame; qualified by s_valid.
- s_data  in  2*I_WIDTH  {re[31:16], im[15:0]}, two's complement Q6.10.
- m_valid  out  1  to detector i_in_valid.
- m_flag  out  1  to detector flagChannelorData (1=channel, 0=data).
- m_data  out  NUM_ANT*2*I_WIDTH  to detector InData.
- m_ready  in  1  from detector o_in_ready.
- frame_done  out  1  one-cycle pulse on completion of the last data word of a frame.
- frame_err  out  1  one-cycle pulse per sync violation.

Behaviour:
- Reset values (async, immediate): m_valid=0, m_flag=0, m_data=0, frame_done=0, frame_err=0, lane_cnt=0, word_cnt=0, pack_full=0, FSM=HUNT. s_ready=1 after Reset_n deasserts.
- Storage: pack register (NUM_ANT lanes + flag + pack_full) and output register (m_data/m_flag/m_valid).
- s_ready = !pack_full. It is registered and has no combinational path from m_ready.
- Lane placement: lane k of a word goes to m_data[(NUM_ANT-k)*32-1 -: 32]. The first sample accepted goes to [127:96], the fourth to [31:0].
- FSM HUNT:
  - An accepted sample with s_sof=1 goes to lane 0, lane_cnt=1, word_cnt=0, state CHAN.
  - An accepted sample with s_sof=0 is dropped, with a frame_err pulse on the next cycle.
- FSM CHAN / DATA:
  - Each accepted sample fills lane lane_cnt, and lane_cnt increments.
  - On the NUM_ANT-th sample: pack_full=1, flag=(state==CHAN), lane_cnt=0, word_cnt++.
  - CHAN goes to DATA when word_cnt reaches NUM_CH_WORDS.
  - DATA goes to HUNT when word_cnt reaches NUM_CH_WORDS+NUM_DATA_WORDS. frame_done pulses on the cycle after the completing sample is accepted.
- Early s_sof: s_sof=1 accepted in CHAN/DATA while lane_cnt!=0 or word_cnt!=0:
  - frame_err pulses.
  - Partial lanes are discarded.
  - The sample restarts a frame as lane 0 of word 0 in CHAN.
  - A word already in pack or output register is still delivered unchanged.
- Transfer: pack goes to output on the edge where pack_full && (!m_valid || m_ready). pack_full clears on that edge.
- Latency: 4th sample accepted at edge E, then m_valid=1 after edge E+1 if the output slot is free. Sustained throughput is 4 samples per 5 cycles.
- Output hold: while m_valid && !m_ready, m_data/m_flag/m_valid stay stable. m_valid drops after a handshake edge unless a new word transfers on the same edge.
- Simultaneous output handshake and pack transfer on one edge: the new word replaces the old with m_valid staying 1, and no bubble.
- Reset mid-frame: all in-flight samples and words are lost, and the FSM returns to HUNT. The detector is reset alongside.
- No arithmetic on sample values; bits pass through unmodified.

Test Plan:
- Nominal frame: 60 samples, s_sof on sample 0, value of sample i = {16'(i), 16'(-i)}, m_ready=1.
  -> 15 words; words 0-3 m_flag=1, words 4-14 m_flag=0.
  -> word 0 m_data = {s0,s1,s2,s3}.
  -> exactly one frame_done, after sample 59; frame_err never.
- Backpressure: m_ready=0 for 10 cycles after word 2 appears.
  -> m_data/m_flag held constant.
  -> s_ready=0 once the next pack fills.
  -> after release, words 2,3,4 delivered in order with no loss or duplication.
- Missing sof: 3 samples with s_sof=0 in HUNT, then a valid frame.
  -> 3 frame_err pulses, no m_valid before the valid frame; the valid frame then delivers 15 words correctly.
- Early sof: s_sof=1 on sample 22 of a frame.
  -> 1 frame_err pulse.
  -> samples 20-21 discarded; words 0-4 already delivered unchanged.
  -> next word = {s22..s25} with m_flag=1, and a full new frame follows.
- Reset mid-frame: Reset_n low for 2 cycles while word 6 is held with m_ready=0.
  -> m_valid=0 immediately (async).
  -> s_ready=1 after release; a following frame is packed from word 0 with m_flag=1.
- Back-to-back frames: 120 samples with s_sof on samples 0 and 60, m_ready=1.
  -> 30 words, flag pattern 4x1, 11x0 repeated; 2 frame_done pulses, no frame_err.
